// File: rtl/frame_sync_controller_if.sv
// ============================================================================
// frame_sync_controller_if : serial bit input and framed payload output bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface frame_sync_controller_if;
  logic       sequence_in;
  logic       bit_valid;
  logic       payload_bit;
  logic       payload_valid;
  logic       payload_last;
  logic       frame_start;
  logic       locked;
  logic       sync_err;
  logic [1:0] state;

  // master drives the bit stream and observes the framed payload
  modport master (
    output sequence_in, bit_valid,
    input  payload_bit, payload_valid, payload_last, frame_start,
           locked, sync_err, state
  );

  modport slave (
    input  sequence_in, bit_valid,
    output payload_bit, payload_valid, payload_last, frame_start,
           locked, sync_err, state
  );
endinterface

`default_nettype wire

// File: rtl/frame_sync_controller.sv
// ============================================================================
// frame_sync_controller : hunt/confirm/lock serial frame synchroniser with
// flywheel; FRAME_SYNC_STATS_EN adds frames_ok/lock_losses counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_sync_controller #(
  parameter int                  SYNC_LEN    = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 4'b1011,
  parameter int                  PAYLOAD_LEN = 8,
  parameter int                  LOCK_COUNT  = 2,
  parameter int                  MISS_LIMIT  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  frame_sync_controller_if.slave bus
`ifdef FRAME_SYNC_STATS_EN
  ,
  output logic [15:0]            frames_ok,
  output logic [15:0]            lock_losses
`endif
);

  localparam int FRAME_LEN = PAYLOAD_LEN + SYNC_LEN;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W    = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {
    HUNT     = 2'b00,
    CHECK    = 2'b01,
    LOCKED   = 2'b10,
    FLYWHEEL = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_LEN-2:0] sh_q, sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                payload_bit_q, payload_bit_d;
  logic                payload_valid_q, payload_valid_d;
  logic                payload_last_q, payload_last_d;
  logic                frame_start_q, frame_start_d;
  logic                sync_err_q, sync_err_d;

  logic [SYNC_LEN-1:0] window;
  logic                match;
  logic                at_check;
  logic [GOOD_W-1:0]   good_inc;
  logic [MISS_W-1:0]   miss_inc;

  assign window   = {sh_q, bus.sequence_in};
  assign match    = bus.bit_valid && (window == SYNC_WORD);
  assign at_check = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign good_inc = good_q + GOOD_W'(1);
  assign miss_inc = miss_q + MISS_W'(1);

  always_comb begin
    state_d         = state_q;
    sh_d            = sh_q;
    cnt_d           = cnt_q;
    good_d          = good_q;
    miss_d          = miss_q;
    payload_bit_d   = payload_bit_q;
    payload_valid_d = 1'b0;
    payload_last_d  = 1'b0;
    frame_start_d   = 1'b0;
    sync_err_d      = 1'b0;

    if (bus.bit_valid) begin
      sh_d  = window[SYNC_LEN-2:0];
      cnt_d = at_check ? '0 : cnt_q + CNT_W'(1);

      // payload bits are sampled using the pre-transition state
      if (state_q[1] && (cnt_q < CNT_W'(PAYLOAD_LEN))) begin
        payload_bit_d   = bus.sequence_in;
        payload_valid_d = 1'b1;
        payload_last_d  = (cnt_q == CNT_W'(PAYLOAD_LEN - 1));
      end

      unique case (state_q)
        HUNT: begin
          if (match) begin
            state_d = CHECK;
            cnt_d   = '0;
            good_d  = '0;
          end
        end
        CHECK: begin
          if (at_check) begin
            if (match) begin
              good_d = good_inc;
              if (good_inc == GOOD_W'(LOCK_COUNT)) begin
                state_d       = LOCKED;
                frame_start_d = 1'b1;
              end
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          if (at_check) begin
            if (match) begin
              frame_start_d = 1'b1;
            end else if (MISS_LIMIT == 1) begin
              state_d    = HUNT;
              sync_err_d = 1'b1;
            end else begin
              state_d = FLYWHEEL;
              miss_d  = MISS_W'(1);
            end
          end
        end
        FLYWHEEL: begin
          if (at_check) begin
            if (match) begin
              state_d       = LOCKED;
              miss_d        = '0;
              frame_start_d = 1'b1;
            end else begin
              miss_d = miss_inc;
              if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                state_d    = HUNT;
                sync_err_d = 1'b1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= HUNT;
      sh_q            <= '0;
      cnt_q           <= '0;
      good_q          <= '0;
      miss_q          <= '0;
      payload_bit_q   <= 1'b0;
      payload_valid_q <= 1'b0;
      payload_last_q  <= 1'b0;
      frame_start_q   <= 1'b0;
      sync_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      sh_q            <= sh_d;
      cnt_q           <= cnt_d;
      good_q          <= good_d;
      miss_q          <= miss_d;
      payload_bit_q   <= payload_bit_d;
      payload_valid_q <= payload_valid_d;
      payload_last_q  <= payload_last_d;
      frame_start_q   <= frame_start_d;
      sync_err_q      <= sync_err_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.locked        = state_q[1];
  assign bus.payload_bit   = payload_bit_q;
  assign bus.payload_valid = payload_valid_q;
  assign bus.payload_last  = payload_last_q;
  assign bus.frame_start   = frame_start_q;
  assign bus.sync_err      = sync_err_q;

`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] frames_ok_q, lock_losses_q;

  // saturating counters track the pulses issued on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frames_ok_q   <= '0;
      lock_losses_q <= '0;
    end else begin
      if (frame_start_d && (frames_ok_q != 16'hFFFF)) begin
        frames_ok_q <= frames_ok_q + 16'd1;
      end
      if (sync_err_d && (lock_losses_q != 16'hFFFF)) begin
        lock_losses_q <= lock_losses_q + 16'd1;
      end
    end
  end

  assign frames_ok   = frames_ok_q;
  assign lock_losses = lock_losses_q;
`endif

endmodule

`default_nettype wire
